// File: rtl/obstacle_spawner.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// obstacle_spawner
//
// Schedules obstacles for the obstacle draw stage. After a pseudo-random gap,
// counted in scroll ticks, it raises a level-held spawn request. The request
// stays up until the draw stage reports the obstacle on screen. Once the
// obstacle leaves the screen, the next gap is loaded. Gaps shrink as the
// difficulty level rises.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous reset, active-low
//   tick_i         one-cycle scroll-step enable
//   gamestate_i    00 UnBegin, 01 Running, 10 Dead, 11 treated as UnBegin
//   obs_active_i   obstacle currently visible on screen
//   obs_spawn_o    spawn request, level-held until obs_active_i rises
//   obs_kind_o     suggested obstacle type, valid while obs_spawn_o=1
//   speed_level_o  difficulty level 0..7
//   spawn_count_o  obstacles that completed a pass, wraps 255->0
// -----------------------------------------------------------------------------
module obstacle_spawner #(
   parameter logic [15:0] SEED        = 16'hACE1,  // must be nonzero
   parameter int unsigned FIRST_GAP   = 60,
   parameter int unsigned MIN_GAP     = 40,
   parameter logic [7:0]  GAP_MASK    = 8'h3F,
   parameter int unsigned LEVEL_STEP  = 4,
   parameter int unsigned LEVEL_EVERY = 5
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tick_i,
   input  logic [1:0] gamestate_i,
   input  logic       obs_active_i,
   output logic       obs_spawn_o,
   output logic [1:0] obs_kind_o,
   output logic [2:0] speed_level_o,
   output logic [7:0] spawn_count_o
);

   // Gap arithmetic is 10 bits wide so MIN_GAP + masked random part cannot wrap.
   localparam int unsigned GAP_W = 10;
   // level_cnt only counts 0 .. LEVEL_EVERY-1.
   localparam int unsigned LVL_W = (LEVEL_EVERY > 1) ? $clog2(LEVEL_EVERY) : 1;

   localparam logic [1:0] GS_RUNNING = 2'b01;
   localparam logic [1:0] GS_DEAD    = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GAP,
      ST_REQ,
      ST_WAIT_CLEAR
   } state_e;

   state_e             state_q,       state_d;
   logic [15:0]        lfsr_q,        lfsr_d;
   logic [GAP_W-1:0]   gap_cnt_q,     gap_cnt_d;
   logic [LVL_W-1:0]   level_cnt_q,   level_cnt_d;
   logic [2:0]         speed_level_q, speed_level_d;
   logic [7:0]         spawn_count_q, spawn_count_d;
   logic [1:0]         obs_kind_q,    obs_kind_d;

   logic               running;
   logic               lfsr_fb;
   logic [GAP_W-1:0]   rand_part;
   logic [GAP_W-1:0]   level_cut;
   logic [GAP_W-1:0]   rand_adj;
   logic [GAP_W-1:0]   gap_load;

   assign running = (gamestate_i == GS_RUNNING);

   // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, shifting left.
   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // Next gap from the current (pre-advance) LFSR and the current level.
   // The level reduction saturates at zero instead of underflowing, so the
   // gap never falls below MIN_GAP.
   always_comb begin
      rand_part = {2'b00, lfsr_q[7:0] & GAP_MASK};
      level_cut = GAP_W'(speed_level_q) * GAP_W'(LEVEL_STEP);
      rand_adj  = (rand_part > level_cut) ? (rand_part - level_cut) : '0;
      gap_load  = GAP_W'(MIN_GAP) + rand_adj;
   end

   // Next-state and datapath logic.
   // NOTE: every signal driven here receives a default first. A path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d       = state_q;
      lfsr_d        = lfsr_q;
      gap_cnt_d     = gap_cnt_q;
      level_cnt_d   = level_cnt_q;
      speed_level_d = speed_level_q;
      spawn_count_d = spawn_count_q;
      obs_kind_d    = obs_kind_q;

      if (running) begin
         if (tick_i) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
         end

         // Each state sees only its own events. A tick arriving on a
         // transition edge is consumed by the state being left.
         case (state_q)
            ST_IDLE: begin
               gap_cnt_d = GAP_W'(FIRST_GAP);
               state_d   = ST_GAP;
            end

            ST_GAP: begin
               // obs_active_i is deliberately ignored here.
               if (tick_i) begin
                  gap_cnt_d = gap_cnt_q - GAP_W'(1);
                  if (gap_cnt_q == GAP_W'(1)) begin
                     state_d    = ST_REQ;
                     obs_kind_d = lfsr_q[1:0];
                  end
               end
            end

            ST_REQ: begin
               // Wait for the draw stage, with no timeout.
               if (obs_active_i) begin
                  state_d = ST_WAIT_CLEAR;
               end
            end

            ST_WAIT_CLEAR: begin
               if (!obs_active_i) begin
                  state_d       = ST_GAP;
                  gap_cnt_d     = gap_load;
                  spawn_count_d = spawn_count_q + 8'd1;
                  if (level_cnt_q == LVL_W'(LEVEL_EVERY - 1)) begin
                     level_cnt_d = '0;
                     if (speed_level_q != 3'd7) begin
                        speed_level_d = speed_level_q + 3'd1;
                     end
                  end else begin
                     level_cnt_d = level_cnt_q + LVL_W'(1);
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (gamestate_i == GS_DEAD) begin
         // Frozen: every default already holds the current value.
      end else begin
         // UnBegin (00 or 11) ends the game. The LFSR keeps its value so
         // the next game takes a different sequence.
         state_d       = ST_IDLE;
         gap_cnt_d     = '0;
         level_cnt_d   = '0;
         speed_level_d = '0;
         spawn_count_d = '0;
      end
   end

   // NOTE: state registers take non-blocking assignments. Every register then
   // updates from the same pre-edge values, whatever the statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q       <= ST_IDLE;
         lfsr_q        <= SEED;
         gap_cnt_q     <= '0;
         level_cnt_q   <= '0;
         speed_level_q <= '0;
         spawn_count_q <= '0;
         obs_kind_q    <= '0;
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         gap_cnt_q     <= gap_cnt_d;
         level_cnt_q   <= level_cnt_d;
         speed_level_q <= speed_level_d;
         spawn_count_q <= spawn_count_d;
         obs_kind_q    <= obs_kind_d;
      end
   end

   // The request is held in REQ and masked whenever the game is not Running.
   // A REQ frozen by Dead therefore reappears on the first Running cycle.
   // Any other gamestate forces the state to IDLE on the next edge.
   assign obs_spawn_o   = (state_q == ST_REQ) && running;
   assign obs_kind_o    = obs_kind_q;
   assign speed_level_o = speed_level_q;
   assign spawn_count_o = spawn_count_q;

endmodule
